// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_pkg
// Purpose  : Shared types and constants for the code decoder chain.
//            state_e : common progress states (IDLE/BUSY/DONE/ERROR)
//            code_t  : 4-bit code word
//            SEQ_TIMEOUT_DEF : default stall timeout for code_sequencer
// Revision : 1.0 - initial release
// ============================================================================
package config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

  typedef logic [3:0] code_t;

  localparam int SEQ_TIMEOUT_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/code_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : code_sequencer_if
// Purpose  : Valid/ready code stream between code_sequencer and the decoder.
// Signals  : code_valid - producer has a code on the bus
//            code       - 4-bit code word
//            code_ready - consumer accepts the code this cycle
// Modports : master (producer), slave (consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface code_sequencer_if;

  logic               code_valid;
  config_pkg::code_t  code;
  logic               code_ready;

  modport master (output code_valid, output code, input  code_ready);
  modport slave  (input  code_valid, input  code, output code_ready);

endinterface
`default_nettype wire

// File: rtl/seq_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_stall_timer
// Purpose  : Counts consecutive stalled cycles and flags the cycle in which
//            the count reaches TIMEOUT.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            en      - stalled this cycle (valid && !ready)
//            clr     - restart count (handshake or not streaming)
//            expired - this is the TIMEOUT-th consecutive stalled cycle
// Revision : 1.0 - initial release
// ============================================================================
module seq_stall_timer #(
  parameter int TIMEOUT = config_pkg::SEQ_TIMEOUT_DEF,
  parameter int STALL_W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [STALL_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag fires while the TIMEOUT-th stalled cycle is in progress so the
  // owner changes state on the edge that closes it.
  assign expired = en && !clr && (r_cnt == STALL_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/code_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : code_sequencer
// Purpose  : Generates a burst of consecutive 4-bit codes on request and
//            presents them over a valid/ready handshake, with a stall
//            watchdog that forces ERROR when the consumer stops accepting.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            start       - burst request (IDLE only)
//            start_code  - first code of the burst
//            burst_len   - beats minus one
//            abort       - terminate burst, back to IDLE
//            clr_err     - leave ERROR
//            bus         - code stream (master side)
//            busy/done/err/state_o - registered state decodes
//            code_par    - odd parity of code (CODE_SEQ_PARITY_EN only)
// Config   : define CODE_SEQ_PARITY_EN to add the code_par output.
// Revision : 1.0 - initial release
// ============================================================================
module code_sequencer
  import config_pkg::*;
#(
  parameter int TIMEOUT = SEQ_TIMEOUT_DEF,
  parameter int STALL_W = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  code_t                   start_code,
  input  logic [3:0]              burst_len,
  input  logic                    abort,
  input  logic                    clr_err,
  code_sequencer_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output state_e                  state_o
`ifdef CODE_SEQ_PARITY_EN
  ,
  output logic                    code_par
`endif
);

  state_e     r_state, w_state_nxt;
  code_t      r_code,  w_code_nxt;
  logic [3:0] r_len,   w_len_nxt;
  logic [3:0] r_beat,  w_beat_nxt;

  logic w_valid;
  logic w_hs;
  logic w_stall;
  logic w_clr;
  logic w_expired;

  // Valid is a pure state decode, so no input reaches any output directly.
  assign w_valid = (r_state == BUSY);
  assign w_hs    = w_valid &&  bus.code_ready;
  assign w_stall = w_valid && !bus.code_ready;
  assign w_clr   = w_hs || (r_state != BUSY);

  seq_stall_timer #(
    .TIMEOUT (TIMEOUT),
    .STALL_W (STALL_W)
  ) u_stall_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_stall),
    .clr     (w_clr),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = BUSY;
          w_code_nxt  = start_code;
          w_len_nxt   = burst_len;
          w_beat_nxt  = '0;
        end
      end
      BUSY: begin
        // abort wins even over a simultaneous handshake; that beat is
        // consumed downstream but not counted here.
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_expired) begin
          w_state_nxt = ERROR;
        end else if (w_hs) begin
          w_code_nxt = r_code + 4'd1;
          w_beat_nxt = r_beat + 4'd1;
          if (r_beat == r_len) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      ERROR: begin
        if (clr_err) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef CODE_SEQ_PARITY_EN
  logic r_par;

  // Parity is taken from the next code so it lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b1;
    end else begin
      r_par <= ~^w_code_nxt;
    end
  end

  assign code_par = r_par;
`endif

  assign bus.code_valid = w_valid;
  assign bus.code       = r_code;
  assign busy           = (r_state == BUSY);
  assign done           = (r_state == DONE);
  assign err            = (r_state == ERROR);
  assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_sequencer
// Purpose  : Self-checking bench for code_sequencer. Stimulus pushes the
//            expected code of every beat into a queue; a monitor pops and
//            compares on each handshake and tracks done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_sequencer;
  import config_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  code_t      start_code = '0;
  logic [3:0] burst_len = '0;
  logic       abort = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  state_e     state_o;
`ifdef CODE_SEQ_PARITY_EN
  logic       code_par;
`endif

  code_sequencer_if bus();

  always #5 clk = ~clk;

  code_sequencer #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_code (start_code),
    .burst_len  (burst_len),
    .abort      (abort),
    .clr_err    (clr_err),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_o    (state_o)
`ifdef CODE_SEQ_PARITY_EN
    ,
    .code_par   (code_par)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  code_t exp_q[$];
  int    done_cnt   = 0;
  logic  hold_en    = 1'b1;
  logic  prev_stall = 1'b0;
  logic  prev_done  = 1'b0;
  code_t prev_code  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (hold_en && prev_stall)
        check("stall_hold", {bus.code_valid, bus.code}, {1'b1, prev_code});
      if (bus.code_valid && bus.code_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat_code", bus.code, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", prev_done, 0);
        check("done_valid_low", bus.code_valid, 0);
      end
`ifdef CODE_SEQ_PARITY_EN
      check("code_par", code_par, ~^bus.code);
`endif
      prev_stall = bus.code_valid && !bus.code_ready;
      prev_code  = bus.code;
      prev_done  = done;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_state", state_o, IDLE);
    check("rst_valid", bus.code_valid, 0);
    check("rst_code", bus.code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
`ifdef CODE_SEQ_PARITY_EN
    check("rst_par", code_par, 1);
`endif
  endtask

  // Full burst: expected codes are start_code + i (mod 16) for i = 0..len.
  task automatic run_burst(input code_t s, input logic [3:0] len, input int first_low, input bit rnd);
    int lows;
    bit seen;
    int d0;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(code_t'(int'(s) + i));
    d0 = done_cnt;
    start_code = s;
    burst_len  = len;
    start      = 1'b1;
    bus.code_ready = 1'b0;
    tick();
    start = 1'b0;
    lows = 0;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c < first_low) bus.code_ready = 1'b0;
      else if (rnd && lows < 4 && $urandom_range(0, 2) == 0) bus.code_ready = 1'b0;
      else bus.code_ready = 1'b1;
      lows = bus.code_ready ? 0 : lows + 1;
      @(negedge clk);
      if (c == 0) begin
        check("first_valid", bus.code_valid, 1);
        check("first_code", bus.code, s);
      end
      if (c < first_low) check("stalled_code", bus.code, s);
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", seen, 1);
    start = 1'b1;                // start during DONE must be ignored
    tick();
    start = 1'b0;
    bus.code_ready = 1'b0;
    @(negedge clk);
    check("back_idle", state_o, IDLE);
    check("done_count", done_cnt - d0, 1);
    check("sb_drained", exp_q.size(), 0);
    check("no_err", err, 0);
    tick();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int d0;
    bus.code_ready = 1'b0;
    #12;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_burst(4'd3, 4'd2, 0, 1'b0);     // 3,4,5
    run_burst(4'd14, 4'd3, 0, 1'b0);    // 14,15,0,1 wrap
    run_burst(4'd7, 4'd1, 3, 1'b0);     // 7 held 4 cycles, then 8
    for (int k = 0; k < 25; k++)
      run_burst(code_t'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 1'b1);

    // Watchdog: 8 stalled cycles force ERROR.
    hold_en = 1'b0;
    start_code = 4'd9;
    burst_len  = 4'd5;
    start = 1'b1;
    bus.code_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) begin
        check("to_not_early", err, 0);
        check("to_still_busy", state_o, BUSY);
      end
    end
    @(negedge clk);
    check("to_err", err, 1);
    check("to_state", state_o, ERROR);
    check("to_valid", bus.code_valid, 0);
    check("to_busy", busy, 0);
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("err_hold", state_o, ERROR);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    check("clr_idle", state_o, IDLE);
    check("clr_err_low", err, 0);
    tick();

    // Abort together with a handshake: that beat is still seen downstream.
    d0 = done_cnt;
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd6);
    start_code = 4'd5;
    burst_len  = 4'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.code_ready = 1'b1;
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_code", bus.code, 6);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", state_o, IDLE);
    check("abort_valid", bus.code_valid, 0);
    check("abort_err", err, 0);

    // Abort in the same cycle the watchdog would expire.
    bus.code_ready = 1'b0;
    tick();
    start_code = 4'd2;
    burst_len  = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    abort = 1'b1;
    @(negedge clk);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_to_idle", state_o, IDLE);
    check("abort_to_err", err, 0);
    repeat (2) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb_drained", exp_q.size(), 0);

    // Reset during beat 2 of a 16-beat burst.
    hold_en = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(4'd3);
    start_code = 4'd3;
    burst_len  = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.code_ready = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    bus.code_ready = 1'b0;
    repeat (2) tick();
    check("post_rst_idle", state_o, IDLE);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_sb", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
